// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the convolution datapath fill stage.
//   DATA_W         - default stream/buffer word width (four packed 16-bit values)
//   ADDR_W         - default buffer address width
//   loader_state_t - buf_loader sequencing states
//   buf_sel_t      - which buffer a registered write targets
package cnn_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_IFM = 2'd1,
    LOAD_W   = 2'd2,
    DONE     = 2'd3
  } loader_state_t;

  typedef enum logic {
    BUF_IFM = 1'b0,
    BUF_W   = 1'b1
  } buf_sel_t;

endpackage

// File: rtl/buf_loader_if.sv
// buf_loader_if: word stream in, shared buffer write port out.
//   s_data/s_valid/s_ready        - valid/ready word stream
//   wr_addr/wr_data               - write address/data shared by both buffers
//   ifm_ena/ifm_wea, w_ena/w_wea  - per-buffer enable / write enable
// Modports:
//   master - environment side: sources the stream, observes the write port
//   slave  - loader side: sinks the stream, drives the write port
interface buf_loader_if #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ifm_ena;
  logic              ifm_wea;
  logic              w_ena;
  logic              w_wea;

  modport master (
    output s_data, s_valid,
    input  s_ready,
    input  wr_addr, wr_data, ifm_ena, ifm_wea, w_ena, w_wea
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready,
    output wr_addr, wr_data, ifm_ena, ifm_wea, w_ena, w_wea
  );

endinterface

// File: rtl/buf_loader_wr_port_reg.sv
// wr_port_reg: registered buffer write port for buf_loader.
// Captures one accepted word per cycle and presents it to the buffers for
// exactly the following cycle, decoding the per-buffer enables from the
// registered buffer select.
//   clk, rst             - clock, asynchronous active-high reset
//   i_we                 - a word was accepted this cycle
//   i_sel                - target buffer of the accepted word
//   i_addr, i_data       - buffer address / data of the accepted word
//   o_addr, o_data       - registered address / data
//   o_ifm_ena, o_ifm_wea - IFM buffer enable / write enable
//   o_w_ena, o_w_wea     - weight buffer enable / write enable
module wr_port_reg #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  cnn_pkg::buf_sel_t  i_sel,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_data,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_ifm_ena,
  output logic               o_ifm_wea,
  output logic               o_w_ena,
  output logic               o_w_wea
);

  import cnn_pkg::*;

  logic              r_we;
  buf_sel_t          r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Address/data only move on an accepted word; the enables alone qualify
  // the cycle, so stale values between writes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_sel  <= BUF_IFM;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= i_we;
      if (i_we) begin
        r_sel  <= i_sel;
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end

  assign o_addr    = r_addr;
  assign o_data    = r_data;
  // A single registered select makes the two buffers mutually exclusive.
  assign o_ifm_ena = r_we && (r_sel == BUF_IFM);
  assign o_ifm_wea = r_we && (r_sel == BUF_IFM);
  assign o_w_ena   = r_we && (r_sel == BUF_W);
  assign o_w_wea   = r_we && (r_sel == BUF_W);

endmodule

// File: rtl/buf_loader.sv
// buf_loader: counted, back-pressured fill of the IFM buffer followed by the
// weight buffer from a valid/ready word stream.
//   clk, rst   - clock, asynchronous active-high reset
//   start      - begins a load; honoured only while idle
//   ifm_words  - IFM word count, sampled on an honoured start
//   w_words    - weight word count, sampled on an honoured start
//   bus        - stream input and shared buffer write port (slave modport)
//   busy       - load in progress (cycle after start up to done)
//   done       - one-cycle pulse after the final buffer write
// Sequence: IDLE -> LOAD_IFM -> LOAD_W -> DONE -> IDLE; empty phases are
// skipped. Addresses restart at 0 per buffer and wrap modulo 2^ADDR_W.
module buf_loader #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] ifm_words,
  input  logic [CNT_W-1:0] w_words,
  buf_loader_if.slave      bus,
  output logic             busy,
  output logic             done
);

  import cnn_pkg::*;

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_ifm_n;
  logic [CNT_W-1:0]  r_w_n;
  logic              r_s_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic              w_last_ifm;
  logic              w_last_w;
  buf_sel_t          w_sel;
  logic [ADDR_W-1:0] w_addr;

  assign w_xfer     = bus.s_valid && r_s_ready;
  // Counts are non-zero whenever their LOAD state is active, so the -1
  // never underflows where it matters.
  assign w_last_ifm = (r_cnt == r_ifm_n - CNT_W'(1));
  assign w_last_w   = (r_cnt == r_w_n - CNT_W'(1));
  assign w_sel      = (r_state == LOAD_W) ? BUF_W : BUF_IFM;
  assign w_addr     = ADDR_W'(r_cnt);

  // s_ready is registered alongside the state: it is set on entry to a LOAD
  // state and cleared on the edge that leaves for DONE, so it equals
  // "state is LOAD_*" without any path from s_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ifm_n   <= '0;
      r_w_n     <= '0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_ifm_n <= ifm_words;
            r_w_n   <= w_words;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (ifm_words != '0) begin
              r_state   <= LOAD_IFM;
              r_s_ready <= 1'b1;
            end else if (w_words != '0) begin
              r_state   <= LOAD_W;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= DONE;
            end
          end
        end

        LOAD_IFM: begin
          if (w_xfer) begin
            if (w_last_ifm) begin
              r_cnt <= '0;
              if (r_w_n != '0) begin
                r_state <= LOAD_W;
              end else begin
                r_state   <= DONE;
                r_s_ready <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        LOAD_W: begin
          if (w_xfer) begin
            if (w_last_w) begin
              r_cnt     <= '0;
              r_state   <= DONE;
              r_s_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = r_s_ready;
  assign busy        = r_busy;
  assign done        = r_done;

  wr_port_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_xfer),
    .i_sel     (w_sel),
    .i_addr    (w_addr),
    .i_data    (bus.s_data),
    .o_addr    (bus.wr_addr),
    .o_data    (bus.wr_data),
    .o_ifm_ena (bus.ifm_ena),
    .o_ifm_wea (bus.ifm_wea),
    .o_w_ena   (bus.w_ena),
    .o_w_wea   (bus.w_wea)
  );

endmodule

// File: tb/tb_buf_loader.sv
// tb_buf_loader: table-driven load sequences with a write scoreboard, plus
// hand-written reset and reset-abort sequences.
module tb_buf_loader;

  typedef struct {
    logic        is_w;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int unsigned ifm;
    int unsigned w;
    bit          bp;       // s_valid low on the first LOAD cycle, then alternating
    bit          restart;  // extra start with other counts mid-load
    int unsigned exp_lat;  // edges from the start edge (counted as 1) to done visible
    int unsigned exp_hs;   // expected handshakes
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] ifm_words;
  logic [15:0] w_words;
  logic        busy;
  logic        done;

  buf_loader_if #(.DATA_W(64), .ADDR_W(16)) bus ();

  buf_loader #(
    .DATA_W (64),
    .ADDR_W (16),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ifm_words (ifm_words),
    .w_words   (w_words),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  wr_t         exp_q[$];
  vec_t        vecs[8];
  int unsigned tag;
  int unsigned cur_ifm;
  int unsigned n_words;
  int unsigned k;
  int unsigned edges;
  int unsigned n_hs;
  int unsigned n_spur;
  int unsigned done_cnt;
  int unsigned done_edge;
  logic        busy_at_done;
  bit          bp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int unsigned idx);
    return {32'(tag), 32'(idx + 1)};
  endfunction

  task automatic begin_load(input int unsigned ni, input int unsigned nw, input bit b);
    start     = 1'b1;
    ifm_words = 16'(ni);
    w_words   = 16'(nw);
    cur_ifm   = ni;
    n_words   = ni + nw;
    bp        = b;
    k         = 0;
    edges     = 0;
    n_hs      = 0;
    n_spur    = 0;
    done_cnt  = 0;
    done_edge = 0;
    busy_at_done = 1'bx;
  endtask

  // One clock: record the handshake about to happen, clock, observe, drive.
  task automatic cycle();
    wr_t e;
    wr_t g;
    if (bus.s_valid && bus.s_ready) begin
      e.is_w = (k >= cur_ifm);
      e.addr = e.is_w ? 16'(k - cur_ifm) : 16'(k);
      e.data = word_of(k);
      exp_q.push_back(e);
      k++;
      n_hs++;
    end
    @(posedge clk);
    edges++;
    #1;
    start = 1'b0;
    if (bus.ifm_ena || bus.ifm_wea || bus.w_ena || bus.w_wea) begin
      if (exp_q.size() == 0) begin
        n_spur++;
      end else begin
        g = exp_q.pop_front();
        check("wr_enables", 128'({bus.ifm_ena, bus.ifm_wea, bus.w_ena, bus.w_wea}),
              g.is_w ? 128'(4'b0011) : 128'(4'b1100));
        check("wr_addr", 128'(bus.wr_addr), 128'(g.addr));
        check("wr_data", 128'(bus.wr_data), 128'(g.data));
      end
    end
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_edge    = edges;
        busy_at_done = busy;
      end
    end
    if (k < n_words && (!bp || (edges % 2 == 0))) begin
      bus.s_valid = 1'b1;
      bus.s_data  = word_of(k);
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = {$urandom, $urandom};
    end
  endtask

  task automatic run_vec(input vec_t v);
    begin_load(v.ifm, v.w, v.bp);
    while (done_cnt == 0 && edges < 60) begin
      cycle();
      if (edges == 1) begin
        check("busy_after_start", 128'(busy), 128'(1'b1));
        check("ready_after_start", 128'(bus.s_ready), 128'(v.ifm + v.w != 0));
      end
      if (v.restart && edges == 3) begin
        start     = 1'b1;
        ifm_words = 16'd1;
        w_words   = 16'd1;
      end
    end
    check("done_latency", 128'(done_edge), 128'(v.exp_lat));
    check("busy_at_done", 128'(busy_at_done), 128'(1'b0));
    check("handshakes", 128'(n_hs), 128'(v.exp_hs));
    check("writes_pending", 128'(exp_q.size()), 128'(0));
    repeat (3) cycle();
    check("done_pulses", 128'(done_cnt), 128'(1));
    check("spurious_writes", 128'(n_spur), 128'(0));
    check("ready_idle", 128'({bus.s_ready, busy}), 128'(2'b00));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    ifm_words   = '0;
    w_words     = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    tag         = 0;

    //          ifm w  bp restart lat hs
    vecs[0] = '{4, 3, 0, 0,  9, 7};
    vecs[1] = '{4, 3, 1, 0, 16, 7};
    vecs[2] = '{0, 2, 0, 0,  4, 2};
    vecs[3] = '{0, 0, 0, 0,  2, 0};
    vecs[4] = '{1, 0, 0, 0,  3, 1};
    vecs[5] = '{5, 1, 1, 0, 14, 6};
    vecs[6] = '{4, 3, 0, 1,  9, 7};
    vecs[7] = '{1, 1, 0, 0,  4, 2};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          128'({bus.s_ready, bus.ifm_ena, bus.ifm_wea, bus.w_ena, bus.w_wea,
                busy, done, bus.wr_addr, bus.wr_data}), 128'(0));
    rst = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      tag = i;
      run_vec(vecs[i]);
    end

    // Reset after two of four IFM words: immediate abort, no done.
    tag = 20;
    begin_load(4, 3, 1'b0);
    repeat (3) cycle();
    check("abort_words_written", 128'(k), 128'(2));
    rst = 1'b1;
    #1;
    check("abort_outputs",
          128'({bus.s_ready, bus.ifm_ena, bus.ifm_wea, bus.w_ena, bus.w_wea,
                busy, done, bus.wr_addr, bus.wr_data}), 128'(0));
    n_words = 0;
    bus.s_valid = 1'b0;
    repeat (2) cycle();
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_ready", 128'(bus.s_ready), 128'(1'b0));
    check("abort_no_writes", 128'(n_spur), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    tag = 21;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buf_loader.md
# buf_loader

Upstream fill stage for the convolution datapath. Accepts a 64-bit valid/ready word stream and writes it into the input feature-map buffer (`blk_mem_input`), then into the weight buffer (`blk_mem_weight`). Word counts are set per layer, and a one-cycle `done` pulse tells the layer controller both buffers are loaded. It replaces the free-running external `dina`/`wea` drive with a counted, back-pressured load sequence.

## Interface
Parameters:
- `DATA_W`, 64, stream and buffer word width (four packed 16-bit values)
- `ADDR_W`, 16, buffer address width
- `CNT_W`, 16, width of the word-count inputs

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE
- `ifm_words`  in  CNT_W  number of IFM words; sampled when `start` is honoured
- `w_words`  in  CNT_W  number of weight words; sampled when `start` is honoured
- `s_data`  in  DATA_W  stream word
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader can accept a word
- `wr_addr`  out  ADDR_W  buffer write address, shared by both buffers
- `wr_data`  out  DATA_W  buffer write data, shared by both buffers
- `ifm_ena`  out  1  IFM buffer enable (write cycle)
- `ifm_wea`  out  1  IFM buffer write enable
- `w_ena`  out  1  weight buffer enable (write cycle)
- `w_wea`  out  1  weight buffer write enable
- `busy`  out  1  high from the cycle after an honoured `start` until the cycle `done` is asserted
- `done`  out  1  one-cycle pulse when the load is complete

## Operation
States: IDLE, LOAD_IFM, LOAD_W, DONE.

- **IDLE.** `s_ready`=0.
  - On `start`: latch both counts, clear the word counter, and set `busy`.
  - Next state is LOAD_IFM if `ifm_words`≠0; else LOAD_W if `w_words`≠0; else DONE.
- **Transfer.** A transfer occurs when `s_valid`&&`s_ready`. `s_ready`=1 in LOAD_IFM and LOAD_W only.
- **LOAD_IFM.** Each transfer writes `s_data` to IFM address = word counter, then increments the counter.
  - When the counter reaches `ifm_words`−1 on a transfer: clear the counter, then go to LOAD_W (if `w_words`≠0) or to DONE.
- **LOAD_W.** Same behaviour, targeting the weight buffer. Addresses restart at 0.
  - Last transfer (counter = `w_words`−1) goes to DONE.
- **DONE.** Assert `done` for exactly one cycle, clear `busy`, and return to IDLE.
- **Ignored inputs.**
  - `start` outside IDLE is ignored.
  - `s_data` when no transfer occurs is ignored, and no write is issued.
- **Addresses.** The address is the word counter zero-extended or truncated to ADDR_W. Counts above 2^ADDR_W wrap the address modulo 2^ADDR_W.
- **Enables.** `ifm_ena`/`ifm_wea` and `w_ena`/`w_wea` are never high in the same cycle.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. `rst` mid-load aborts immediately: no further writes, no `done`. The buffer contents are left as written.
- **`start` to ready.** `s_ready` rises the cycle after the `start` edge; that is the first LOAD cycle.
- **Write latency.** Writes are registered. A transfer at edge k drives `wr_addr`/`wr_data`/`*_ena`/`*_wea` during cycle k+1, for exactly one cycle.
- **`s_ready`.** Driven from state only, not from `s_valid`. It drops in the cycle after the last transfer of each phase that leads to DONE. It stays high across the LOAD_IFM→LOAD_W transition.
- **Throughput.** One word per cycle while `s_valid` is held high. Bubbles in `s_valid` stall the counters without side effects.
- **`done` timing.** `done` asserts the cycle after the final write cycle. The final buffer write therefore completes before `done` is seen.
- **Zero counts.** With both counts 0, `done` pulses 2 cycles after `start`.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W`, `ADDR_W`
  - state enum `loader_state_t`
  - buffer-select encoding `BUF_IFM`/`BUF_W`
- One sub-module, `wr_port_reg`: registers the addr/data/enable/buffer-select and decodes `*_ena`/`*_wea`. The FSM and counter stay in `buf_loader`.

## Test plan
- **Basic load.** `ifm_words`=4, `w_words`=3, `s_valid` held high, data 0x1…0x7.
  - Expect IFM writes to addr 0–3 with 0x1–0x4.
  - Expect weight writes to addr 0–2 with 0x5–0x7.
  - Expect `done` one cycle after the last write, with 7 `s_ready` handshakes total.
- **Back-pressure.** Same counts, `s_valid` toggled every other cycle.
  - Expect identical buffer contents, no duplicate or skipped addresses, and `done` 7 cycles later than in the basic load.
- **Empty phases.**
  - `ifm_words`=0, `w_words`=2: no IFM writes, weight addr 0–1 written.
  - Both counts 0: `done` 2 cycles after `start`, no writes at all.
- **Ignored start.** `start` pulsed mid-LOAD_IFM with different counts.
  - Expect the original counts honoured and a single `done`.
- **Reset mid-load.** `rst` asserted after 2 of 4 IFM words.
  - Expect all outputs 0 asynchronously, no `done`, and `s_ready`=0.
  - A new `start` after reset reloads correctly from addr 0.
